// File: rtl/intersection_pkg.sv
// Shared phase encoding and lamp patterns for the intersection sequencer.
// Lamp vectors are ordered {mr, my, mg, sr, sy, sg, walk, dont_walk}.
package intersection_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED1    = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED2    = 3'd5,
    PED_WALK    = 3'd6,
    PED_CLEAR   = 3'd7
  } phase_t;

  typedef struct packed {
    logic mr;
    logic my;
    logic mg;
    logic sr;
    logic sy;
    logic sg;
    logic walk;
    logic dont_walk;
  } lamps_t;

  localparam lamps_t LAMPS_MAIN_GREEN  = 8'b0011_0001;
  localparam lamps_t LAMPS_MAIN_YELLOW = 8'b0101_0001;
  localparam lamps_t LAMPS_ALL_RED     = 8'b1001_0001;
  localparam lamps_t LAMPS_SIDE_GREEN  = 8'b1000_0101;
  localparam lamps_t LAMPS_SIDE_YELLOW = 8'b1000_1001;
  localparam lamps_t LAMPS_PED_WALK    = 8'b1001_0010;
  // Flashing of dont_walk during clearance is left to the lamp driver.
  localparam lamps_t LAMPS_PED_CLEAR   = 8'b1001_0001;

  function automatic lamps_t lamps_for(input phase_t p);
    lamps_for = LAMPS_ALL_RED;
    case (p)
      MAIN_GREEN:  lamps_for = LAMPS_MAIN_GREEN;
      MAIN_YELLOW: lamps_for = LAMPS_MAIN_YELLOW;
      SIDE_GREEN:  lamps_for = LAMPS_SIDE_GREEN;
      SIDE_YELLOW: lamps_for = LAMPS_SIDE_YELLOW;
      PED_WALK:    lamps_for = LAMPS_PED_WALK;
      PED_CLEAR:   lamps_for = LAMPS_PED_CLEAR;
      default:     lamps_for = LAMPS_ALL_RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase-duration down-counter: loads on phase entry, decrements on tick,
// holds at zero; expired flags terminal count.
module phase_timer #(
  parameter int               CNT_W     = 6,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             expired
);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      cnt <= RESET_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/intersection_sequencer.sv
// Tick-driven main/side/pedestrian phase sequencer with emergency preempt.
//   state       | meaning
//   MAIN_GREEN  | main road green, waits for C or latched pedestrian request
//   MAIN_YELLOW | main road yellow, fixed length
//   ALL_RED1    | clearance, then arbitrate side / pedestrian / back to main
//   SIDE_GREEN  | side green until max, gap-out (C=0) or emergency
//   SIDE_YELLOW | side road yellow, fixed length
//   ALL_RED2    | clearance before returning to main green
//   PED_WALK    | exclusive pedestrian walk, cut short by emergency
//   PED_CLEAR   | pedestrian clearance, fixed length
module intersection_sequencer
  import intersection_pkg::*;
#(
  parameter int T_MIN_MAIN = 25,
  parameter int T_MAX_SIDE = 25,
  parameter int T_YEL      = 4,
  parameter int T_ALLRED   = 1,
  parameter int T_WALK     = 10,
  parameter int T_PCLR     = 6,
  parameter int CNT_W      = 6
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       C,
  input  logic       ped_req,
  input  logic       emg,
  output logic       MR,
  output logic       MY,
  output logic       MG,
  output logic       SR,
  output logic       SY,
  output logic       SG,
  output logic       walk,
  output logic       dont_walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  phase_t           state;
  phase_t           state_next;
  logic             ped_pending;
  logic             last_ped;
  logic             entering;
  logic             walk_entry;
  logic             side_entry;
  logic             in_ped;
  logic             expired;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;
  lamps_t           lamps;

  function automatic logic [CNT_W-1:0] phase_load(input phase_t p);
    phase_load = CNT_W'(T_ALLRED - 1);
    case (p)
      MAIN_GREEN:              phase_load = CNT_W'(T_MIN_MAIN - 1);
      MAIN_YELLOW,
      SIDE_YELLOW:             phase_load = CNT_W'(T_YEL - 1);
      SIDE_GREEN:              phase_load = CNT_W'(T_MAX_SIDE - 1);
      PED_WALK:                phase_load = CNT_W'(T_WALK - 1);
      PED_CLEAR:               phase_load = CNT_W'(T_PCLR - 1);
      default:                 phase_load = CNT_W'(T_ALLRED - 1);
    endcase
  endfunction

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state       <= MAIN_GREEN;
      ped_pending <= 1'b0;
      last_ped    <= 1'b0;
      ped_ack     <= 1'b0;
    end else begin
      state   <= state_next;
      ped_ack <= walk_entry;
      if (walk_entry) begin
        ped_pending <= 1'b0;
        last_ped    <= 1'b1;
      end else begin
        if (ped_req && !in_ped) ped_pending <= 1'b1;
        if (side_entry)         last_ped    <= 1'b0;
      end
    end
  end

  // Transitions only happen on tick cycles, so every phase entry coincides
  // with a tick and a timed phase lasts exactly its programmed tick count.
  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        MAIN_GREEN:
          if (expired && !emg && (C || ped_pending)) state_next = MAIN_YELLOW;
        MAIN_YELLOW:
          if (expired) state_next = ALL_RED1;
        ALL_RED1:
          if (expired) begin
            if (emg)                     state_next = MAIN_GREEN;
            else if (ped_pending && C)   state_next = last_ped ? SIDE_GREEN : PED_WALK;
            else if (ped_pending)        state_next = PED_WALK;
            else if (C)                  state_next = SIDE_GREEN;
            else                         state_next = MAIN_GREEN;
          end
        SIDE_GREEN:
          if (expired || !C || emg) state_next = SIDE_YELLOW;
        SIDE_YELLOW:
          if (expired) state_next = ALL_RED2;
        ALL_RED2:
          if (expired) state_next = MAIN_GREEN;
        PED_WALK:
          if (expired || emg) state_next = PED_CLEAR;
        PED_CLEAR:
          if (expired) state_next = ALL_RED2;
        default:
          state_next = MAIN_GREEN;
      endcase
    end
  end

  assign entering   = (state_next != state);
  assign walk_entry = entering && (state_next == PED_WALK);
  assign side_entry = entering && (state_next == SIDE_GREEN);
  assign in_ped     = (state == PED_WALK) || (state == PED_CLEAR);
  assign load_val   = phase_load(state_next);

  phase_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (CNT_W'(T_MIN_MAIN - 1))
  ) u_timer (
    .Clk      (Clk),
    .reset    (reset),
    .tick     (tick),
    .load     (entering),
    .load_val (load_val),
    .cnt      (cnt),
    .expired  (expired)
  );

  // The count can never exceed the load value of the phase it belongs to.
  always_ff @(posedge Clk) begin
    if (reset) assert (cnt <= phase_load(state));
  end

  assign lamps     = lamps_for(state);
  assign MR        = lamps.mr;
  assign MY        = lamps.my;
  assign MG        = lamps.mg;
  assign SR        = lamps.sr;
  assign SY        = lamps.sy;
  assign SG        = lamps.sg;
  assign walk      = lamps.walk;
  assign dont_walk = lamps.dont_walk;
  assign phase     = state;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Scoreboard bench for intersection_sequencer: a tick-counting reference model
// pushes expected phase/ped_ack per cycle, the DUT outputs are popped and compared.
module tb_intersection_sequencer;

  localparam int D_MAIN = 25, D_SIDE = 25, D_YEL = 4, D_AR = 1, D_WALK = 10, D_PCLR = 6;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, C = 1'b0, ped_req = 1'b0, emg = 1'b0;
  logic       MR, MY, MG, SR, SY, SG, walk, dont_walk, ped_ack;
  logic [2:0] phase;

  intersection_sequencer dut (
    .Clk(Clk), .reset(reset), .tick(tick), .C(C), .ped_req(ped_req), .emg(emg),
    .MR(MR), .MY(MY), .MG(MG), .SR(SR), .SY(SY), .SG(SG),
    .walk(walk), .dont_walk(dont_walk), .ped_ack(ped_ack), .phase(phase)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] ph;
    logic       ack;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0, n_total = 0;
  logic c_v = 1'b0, p_v = 1'b0, e_v = 1'b0;

  // reference model state: elapsed ticks in phase count upward
  int   m_state = 0, m_el = 0;
  logic m_pp = 1'b0, m_lp = 1'b0, m_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] lamp_ref(input logic [2:0] ph);
    case (ph)
      3'd0:    return 8'b0011_0001;
      3'd1:    return 8'b0101_0001;
      3'd3:    return 8'b1000_0101;
      3'd4:    return 8'b1000_1001;
      3'd6:    return 8'b1001_0010;
      default: return 8'b1001_0001;
    endcase
  endfunction

  function automatic int dur(input int s);
    case (s)
      0:       return D_MAIN;
      1, 4:    return D_YEL;
      3:       return D_SIDE;
      6:       return D_WALK;
      7:       return D_PCLR;
      default: return D_AR;
    endcase
  endfunction

  task automatic model_step();
    int   nx;
    logic ex;
    exp_t e;
    nx = m_state;
    ex = (m_el >= dur(m_state) - 1);
    if (tick) begin
      case (m_state)
        0: if (ex && !emg && (C || m_pp)) nx = 1;
        1: if (ex) nx = 2;
        2: if (ex) begin
             if (emg)            nx = 0;
             else if (m_pp && C) nx = m_lp ? 3 : 6;
             else if (m_pp)      nx = 6;
             else if (C)         nx = 3;
             else                nx = 0;
           end
        3: if (ex || !C || emg) nx = 4;
        4: if (ex) nx = 5;
        5: if (ex) nx = 0;
        6: if (ex || emg) nx = 7;
        default: if (ex) nx = 5;
      endcase
    end
    m_ack = (nx == 6) && (m_state != 6);
    if (m_ack) begin
      m_pp = 1'b0;
      m_lp = 1'b1;
    end else begin
      if (ped_req && m_state < 6) m_pp = 1'b1;
      if (nx == 3 && m_state != 3) m_lp = 1'b0;
    end
    if (nx != m_state) m_el = 0;
    else if (tick && m_el < dur(m_state) - 1) m_el++;
    m_state = nx;
    e.ph  = 3'(m_state);
    e.ack = m_ack;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic t);
    exp_t e;
    @(negedge Clk);
    tick = t; C = c_v; ped_req = p_v; emg = e_v;
    model_step();
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("phase", 32'(phase), 32'(e.ph));
      check("lamps", 32'({MR, MY, MG, SR, SY, SG, walk, dont_walk}), 32'(lamp_ref(e.ph)));
      check("ped_ack", 32'(ped_ack), 32'(e.ack));
    end
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      cyc(1'b1);
      cyc(1'b0);
    end
  endtask

  task automatic ped_pulse();
    p_v = 1'b1;
    cyc(1'b0);
    p_v = 1'b0;
  endtask

  // asynchronous reset asserted between clock edges; outputs must change at once
  task automatic do_reset();
    @(posedge Clk);
    #2;
    tick = 1'b0; ped_req = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_lamps", 32'({MR, MY, MG, SR, SY, SG, walk, dont_walk}), 32'h31);
    check("rst_ack", 32'(ped_ack), 32'd0);
    m_state = 0; m_el = 0; m_pp = 1'b0; m_lp = 1'b0; m_ack = 1'b0;
    repeat (2) @(negedge Clk);
    reset = 1'b1;
  endtask

  initial begin
    do_reset();

    // car demand from reset: MG 25, MY 4, AR 1, SG; gap-out on SG tick 5
    c_v = 1'b1;
    run_ticks(30);  check("s1_sg_entry", 32'(phase), 32'd3);
    run_ticks(4);
    c_v = 1'b0;
    run_ticks(1);   check("s1_gapout", 32'(phase), 32'd4);
    run_ticks(5);   check("s1_back_mg", 32'(phase), 32'd0);

    // single pedestrian pulse, no cars
    run_ticks(2);
    ped_pulse();
    run_ticks(28);  check("s2_walk", 32'(phase), 32'd6);
    run_ticks(10);  check("s2_pclr", 32'(phase), 32'd7);
    run_ticks(7);   check("s2_mg", 32'(phase), 32'd0);

    // both requests from reset: walk first, then side (alternation)
    do_reset();
    c_v = 1'b1;
    ped_pulse();
    run_ticks(30);  check("s3_walk_first", 32'(phase), 32'd6);
    run_ticks(17);  check("s3_mg", 32'(phase), 32'd0);
    ped_pulse();
    run_ticks(30);  check("s3_side_next", 32'(phase), 32'd3);
    run_ticks(3);

    // reset mid SIDE_GREEN with a pedestrian still latched
    do_reset();
    c_v = 1'b0;
    run_ticks(27);  check("s4_no_pending", 32'(phase), 32'd0);
    ped_pulse();
    run_ticks(6);   check("s4_walk", 32'(phase), 32'd6);
    run_ticks(1);
    e_v = 1'b1;
    run_ticks(1);   check("s4_emg_cut", 32'(phase), 32'd7);
    run_ticks(5);   check("s4_pclr_full", 32'(phase), 32'd7);
    run_ticks(1);   check("s4_ar2", 32'(phase), 32'd5);
    run_ticks(1);   check("s4_mg", 32'(phase), 32'd0);
    c_v = 1'b1;
    run_ticks(40);  check("s4_emg_hold", 32'(phase), 32'd0);
    e_v = 1'b0;
    run_ticks(1);   check("s4_release", 32'(phase), 32'd1);

    // side max-out with a long tick-free gap inside SIDE_GREEN
    run_ticks(5);   check("s5_sg", 32'(phase), 32'd3);
    run_ticks(10);
    c_v = 1'b0;
    repeat (100) cyc(1'b0);
    check("s5_frozen", 32'(phase), 32'd3);
    c_v = 1'b1;
    run_ticks(14);  check("s5_sg_last", 32'(phase), 32'd3);
    run_ticks(1);   check("s5_maxout", 32'(phase), 32'd4);
    run_ticks(6);   check("s5_mg", 32'(phase), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
